ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameters: none; the datapath width is fixed at 32 bits.
REQ-002 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 valid_i  in  1  ID-EX register holds an operation to execute.
REQ-005 ready_o  out  1  EX can accept an operation this cycle.
REQ-006 flush_i  in  1  discard the in-flight operation.
REQ-007 rd_addr_i  in  5  destination register address.
REQ-008 rd_wr_en_i  in  1  the operation writes rd.
REQ-009 operand_a_i / operand_b_i  in  32 each  source operands.
REQ-010 alu_operate_i  in  milano_pkg::alu_opt_e  operation select.
REQ-011 we_o  out  1  writeback strobe to regs_file (one cycle per result).
REQ-012 waddr_o  out  5  writeback address.
REQ-013 wdata_o  out  32  writeback data.
REQ-014 busy_o  out  1  high while an iterative divide is in progress.

Function
REQ-015 Acceptance: an operation is accepted at a rising edge where valid_i=1, ready_o=1 and flush_i=0.
REQ-016 ready_o = 1 exactly when the FSM is in IDLE.
REQ-017 FSM states: IDLE and DIV. IDLE->DIV on acceptance of a non-special divide op. DIV->IDLE after 32 iterations, on flush_i, or on reset.
REQ-018 Single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
- The result is registered at the acceptance edge.
- we_o/waddr_o/wdata_o are valid in the following cycle (latency 1).
- Back-to-back acceptance every cycle is supported.
REQ-019 Shift amount = operand_b_i[4:0]. SLT compares signed and SLTU compares unsigned; both yield 32'h0/32'h1. Add and subtract wrap modulo 2^32.
REQ-020 Divide ops (DIV, DIVU, REM, REMU) use a radix-2 restoring divider.
- One quotient bit is produced per cycle, with a 5-bit iteration counter running 0..31.
- Signed ops divide magnitudes and then fix the signs: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
REQ-021 Divide latency: accepted at edge N, the result is registered at edge N+32 and we_o is high in the cycle after edge N+32. busy_o and ~ready_o are high during cycles N+1..N+32.
REQ-022 Divide special cases complete in one cycle, like single-cycle ops:
- divisor==0: DIV/DIVU give 32'hFFFF_FFFF; REM/REMU give the dividend.
- DIV/REM with 32'h8000_0000 / 32'hFFFF_FFFF: quotient 32'h8000_0000, remainder 0.
REQ-023 we_o = 0 whenever rd_wr_en_i=0 or rd_addr_i=0 for the producing operation; waddr_o and wdata_o still update.
REQ-024 we_o is high for exactly one cycle per result; it is 0 in every cycle that has no new result.
REQ-025 Flush during DIV: return to IDLE at that edge and produce no writeback. ready_o is high in the next cycle.
REQ-026 flush_i together with valid_i in IDLE: flush wins; nothing is accepted and we_o=0 next cycle.
REQ-027 The operand, address and op fields are captured at acceptance. Input changes during DIV are ignored.
REQ-028 An unrecognised alu_operate_i is accepted as a one-cycle op with wdata_o=0 and we_o=0.

Reset
REQ-029 While rst_i=1 at an edge:
- FSM goes to IDLE and the counter to 0.
- we_o=0, waddr_o=0, wdata_o=0, busy_o=0.
- ready_o=1 in the cycle after reset.
REQ-030 Reset during DIV aborts the divide with no writeback. Reset has priority over flush_i and valid_i.

Configuration
REQ-031 Macro MILANO_DIV_EN controls the divider.
REQ-032 With MILANO_DIV_EN defined: the divider, the DIV state and busy_o behave per REQ-020..REQ-022.
REQ-033 Without MILANO_DIV_EN:
- no divider logic or DIV state is built; busy_o is tied to 0.
- divide ops complete in one cycle with wdata_o=0 and we_o=0.

Verification
REQ-034 ADD a=32'h7FFF_FFFF, b=1, rd=5, wr_en=1 -> next cycle we_o=1, waddr_o=5, wdata_o=32'h8000_0000.
REQ-035 Three back-to-back ops SUB 5-7, SRA 32'h8000_0000>>4, SLTU 1<2 on rd=1,2,3 -> we_o high in 3 consecutive cycles with wdata 32'hFFFF_FFFE, 32'hF800_0000, 32'h1.
REQ-036 DIV -7/2, rd=4 -> ready_o low for 32 cycles; we_o in cycle 33 with wdata_o=32'hFFFF_FFFD. REM -7/2 -> 32'hFFFF_FFFF.
REQ-037 DIVU 9/0 -> next cycle wdata_o=32'hFFFF_FFFF. DIV 32'h8000_0000/32'hFFFF_FFFF -> 32'h8000_0000. Neither asserts busy_o.
REQ-038 Start DIVU 100/3, assert flush_i at cycle 10 -> no we_o pulse, ready_o=1 at cycle 11. Repeat with rst_i instead -> all outputs 0.
REQ-039 ADD with rd=0 -> we_o=0. With MILANO_DIV_EN undefined, DIV 10/2 -> we_o=0, busy_o never asserted.

Source files
------------

// File: rtl/ex_stage_if.sv
// ---------------------------------------------------------------------------
// milano_pkg / ex_stage_if
//
// milano_pkg holds the ALU operation encoding shared by the ID and EX stages.
// Codes 14 and 15 are deliberately left unassigned; EX treats them as
// one-cycle operations that produce no writeback.
//
// ex_stage_if bundles the ID->EX issue signals and the EX->regs_file
// writeback signals.
//   master : ID side   - drives valid/flush/operands/op/rd, sees ready/wb/busy
//   slave  : EX side   - the mirror image
//
//   valid_i        ID-EX register holds an operation
//   ready_o        EX can accept an operation this cycle
//   flush_i        discard the in-flight operation
//   rd_addr_i      destination register address
//   rd_wr_en_i     the operation writes rd
//   operand_a_i    source operand A (dividend for divides)
//   operand_b_i    source operand B (shift amount / divisor)
//   alu_operate_i  operation select
//   we_o           one-cycle writeback strobe
//   waddr_o        writeback address
//   wdata_o        writeback data
//   busy_o         iterative divide in progress
// ---------------------------------------------------------------------------
package milano_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_DIV  = 4'd10,
        ALU_DIVU = 4'd11,
        ALU_REM  = 4'd12,
        ALU_REMU = 4'd13
    } alu_opt_e;
endpackage

interface ex_stage_if;
    logic                 valid_i;
    logic                 ready_o;
    logic                 flush_i;
    logic [4:0]           rd_addr_i;
    logic                 rd_wr_en_i;
    logic [31:0]          operand_a_i;
    logic [31:0]          operand_b_i;
    milano_pkg::alu_opt_e alu_operate_i;
    logic                 we_o;
    logic [4:0]           waddr_o;
    logic [31:0]          wdata_o;
    logic                 busy_o;

    modport master (
        output valid_i, flush_i, rd_addr_i, rd_wr_en_i,
               operand_a_i, operand_b_i, alu_operate_i,
        input  ready_o, we_o, waddr_o, wdata_o, busy_o
    );

    modport slave (
        input  valid_i, flush_i, rd_addr_i, rd_wr_en_i,
               operand_a_i, operand_b_i, alu_operate_i,
        output ready_o, we_o, waddr_o, wdata_o, busy_o
    );
endinterface

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage - execute stage of the milano core
//
// Executes one ALU operation per accepted issue and writes the result back
// to the register file one cycle later. Divides are performed by a radix-2
// restoring divider taking 32 cycles; during that time the stage is busy and
// refuses new operations.
//
// Ports:
//   clk_i  sole clock, rising edge
//   rst_i  synchronous, active-high reset (beats flush and valid)
//   bus    ex_stage_if.slave: issue handshake, operands, op select,
//          writeback strobe/address/data and busy flag
//
// Configuration macro:
//   MILANO_DIV_EN  when defined, builds the divider and the DIV state.
//                  When undefined, divide ops retire in one cycle with
//                  wdata_o = 0 and no write strobe, and busy_o is tied low.
//
// Timing:
//   one-cycle ops : accepted at edge N, we_o/waddr_o/wdata_o valid after N.
//   iterative div : accepted at edge N, result registered at edge N+32,
//                   busy_o high (ready_o low) for cycles N+1..N+32.
// ---------------------------------------------------------------------------
module ex_stage
    import milano_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    ex_stage_if.slave  bus
);

    localparam int DATA_W = 32;

`ifdef MILANO_DIV_EN
    // Magnitude of a two's-complement value; 32'h8000_0000 maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] f_abs(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] f_neg_if(input logic [DATA_W-1:0] v,
                                                   input logic              neg);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Operand views and one-cycle result
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] w_a_s;
    logic signed [DATA_W-1:0] w_b_s;
    logic [4:0]               w_shamt;
    logic [DATA_W-1:0]        w_fast_res;
    logic                     w_res_valid;   // op is recognised and produces a value now
    logic                     w_idle;
    logic                     w_accept;
    logic                     w_wb_en;       // rd write is meaningful (enabled, not x0)

    assign w_a_s   = bus.operand_a_i;
    assign w_b_s   = bus.operand_b_i;
    assign w_shamt = bus.operand_b_i[4:0];
    assign w_wb_en = bus.rd_wr_en_i && (bus.rd_addr_i != 5'd0);

`ifdef MILANO_DIV_EN
    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_e;

    state_e              r_state;
    logic [4:0]          r_cnt;

    // Divider datapath: r_quo starts as the dividend magnitude and is
    // shifted left each iteration, its MSB feeding the partial remainder
    // while new quotient bits enter at the LSB.
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_dvsr;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_is_rem;
    logic [4:0]          r_div_waddr;
    logic                r_div_we;

    logic                w_start_div;
    logic                w_signed_op;
    logic                w_quo_op;
    logic                w_b_zero;
    logic                w_sovf;
    logic [DATA_W:0]     w_shifted;
    logic [DATA_W:0]     w_trial;
    logic [DATA_W-1:0]   w_rem_nxt;
    logic [DATA_W-1:0]   w_quo_nxt;
    logic [DATA_W-1:0]   w_div_res;

    assign w_signed_op = (bus.alu_operate_i == ALU_DIV) || (bus.alu_operate_i == ALU_REM);
    assign w_quo_op    = (bus.alu_operate_i == ALU_DIV) || (bus.alu_operate_i == ALU_DIVU);
    assign w_b_zero    = (bus.operand_b_i == '0);
    assign w_sovf      = (bus.operand_a_i == 32'h8000_0000) && (bus.operand_b_i == 32'hFFFF_FFFF);

    assign w_idle = (r_state == S_IDLE);
`else
    assign w_idle = 1'b1;
`endif

    assign w_accept = bus.valid_i && !bus.flush_i && w_idle;

    always_comb begin
        w_fast_res  = '0;
        w_res_valid = 1'b1;
`ifdef MILANO_DIV_EN
        w_start_div = 1'b0;
`endif
        case (bus.alu_operate_i)
            ALU_ADD:  w_fast_res = bus.operand_a_i + bus.operand_b_i;
            ALU_SUB:  w_fast_res = bus.operand_a_i - bus.operand_b_i;
            ALU_AND:  w_fast_res = bus.operand_a_i & bus.operand_b_i;
            ALU_OR:   w_fast_res = bus.operand_a_i | bus.operand_b_i;
            ALU_XOR:  w_fast_res = bus.operand_a_i ^ bus.operand_b_i;
            ALU_SLL:  w_fast_res = bus.operand_a_i << w_shamt;
            ALU_SRL:  w_fast_res = bus.operand_a_i >> w_shamt;
            ALU_SRA:  w_fast_res = DATA_W'(w_a_s >>> w_shamt);
            ALU_SLT:  w_fast_res = {31'd0, (w_a_s < w_b_s)};
            ALU_SLTU: w_fast_res = {31'd0, (bus.operand_a_i < bus.operand_b_i)};
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
`ifdef MILANO_DIV_EN
                // Degenerate divides are resolved immediately so they never
                // occupy the iterative divider.
                if (w_b_zero) begin
                    w_fast_res = w_quo_op ? '1 : bus.operand_a_i;
                end else if (w_signed_op && w_sovf) begin
                    w_fast_res = w_quo_op ? 32'h8000_0000 : '0;
                end else begin
                    w_res_valid = 1'b0;
                    w_start_div = 1'b1;
                end
`else
                w_res_valid = 1'b0;
`endif
            end
            default:  w_res_valid = 1'b0;
        endcase
    end

`ifdef MILANO_DIV_EN
    // ------------------------------------------------------------------
    // Divider iteration: one restoring step per cycle
    // ------------------------------------------------------------------
    // Partial remainder < divisor, so the shifted value fits in 33 bits and
    // bit 32 of the trial difference is a reliable "went negative" flag.
    assign w_shifted = {r_rem, r_quo[DATA_W-1]};
    assign w_trial   = w_shifted - {1'b0, r_dvsr};
    assign w_rem_nxt = w_trial[DATA_W] ? w_shifted[DATA_W-1:0] : w_trial[DATA_W-1:0];
    assign w_quo_nxt = {r_quo[DATA_W-2:0], ~w_trial[DATA_W]};
    assign w_div_res = r_is_rem ? f_neg_if(w_rem_nxt, r_neg_r)
                                : f_neg_if(w_quo_nxt, r_neg_q);

    // Datapath registers carry no reset: they are only observed while the
    // FSM is in DIV, and entering DIV always reloads them.
    always_ff @(posedge clk_i) begin
        if (w_accept && w_start_div) begin
            r_rem       <= '0;
            r_quo       <= w_signed_op ? f_abs(w_a_s) : bus.operand_a_i;
            r_dvsr      <= w_signed_op ? f_abs(w_b_s) : bus.operand_b_i;
            r_neg_q     <= w_signed_op && (bus.operand_a_i[DATA_W-1] ^ bus.operand_b_i[DATA_W-1]);
            r_neg_r     <= w_signed_op && bus.operand_a_i[DATA_W-1];
            r_is_rem    <= !w_quo_op;
            r_div_waddr <= bus.rd_addr_i;
            r_div_we    <= w_wb_en;
        end else if (r_state == S_DIV) begin
            r_rem       <= w_rem_nxt;
            r_quo       <= w_quo_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM and writeback registers
    // ------------------------------------------------------------------
    logic              r_we;
    logic [4:0]        r_waddr;
    logic [DATA_W-1:0] r_wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
`ifdef MILANO_DIV_EN
            r_state <= S_IDLE;
            r_cnt   <= '0;
`endif
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            // Strobe defaults low so it lasts exactly one cycle per result.
            r_we <= 1'b0;
`ifdef MILANO_DIV_EN
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_start_div) begin
                            r_state <= S_DIV;
                            r_cnt   <= '0;
                        end else begin
                            r_we    <= w_res_valid && w_wb_en;
                            r_waddr <= bus.rd_addr_i;
                            r_wdata <= w_fast_res;
                        end
                    end
                end
                S_DIV: begin
                    // A flush abandons the divide even on its final step.
                    if (bus.flush_i) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == 5'd31) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_we    <= r_div_we;
                        r_waddr <= r_div_waddr;
                        r_wdata <= w_div_res;
                    end else begin
                        r_cnt   <= r_cnt + 5'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
`else
            if (w_accept) begin
                r_we    <= w_res_valid && w_wb_en;
                r_waddr <= bus.rd_addr_i;
                r_wdata <= w_fast_res;
            end
`endif
        end
    end

    assign bus.ready_o = w_idle;
    assign bus.we_o    = r_we;
    assign bus.waddr_o = r_waddr;
    assign bus.wdata_o = r_wdata;
`ifdef MILANO_DIV_EN
    assign bus.busy_o  = (r_state == S_DIV);
`else
    assign bus.busy_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage - self-checking bench for ex_stage
//
// A driver issues directed and random operations; for each accepted one the
// reference model pushes the expected writeback (address, data, cycle) into
// a queue. A monitor on the falling edge pops and compares on every we_o
// pulse. The driver also checks ready_o/busy_o against the model's notion
// of when the stage is free. Honours MILANO_DIV_EN the same way the design
// does.
// ---------------------------------------------------------------------------
module tb_ex_stage;
    import milano_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if bus();

    ex_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int unsigned at;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc        = 0;
    int unsigned busy_until = 0;
    logic        pend       = 1'b0;
    logic        busy_seen  = 1'b0;
    int          n_chk      = 0;
    int          n_pass     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Behavioural model: result of an op, whether it produces a value, and
    // whether it goes through the 32-cycle divider.
    function automatic void ref_op(input alu_opt_e op, input logic [31:0] a, input logic [31:0] b,
                                   output logic ok, output logic [31:0] r, output logic long_op);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        ok = 1'b1;
        r = '0;
        long_op = 1'b0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = sa >>> b[4:0];
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
`ifdef MILANO_DIV_EN
                if (b == 32'd0) begin
                    r = (op == ALU_DIV || op == ALU_DIVU) ? 32'hFFFF_FFFF : a;
                end else if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = (op == ALU_DIV) ? 32'h8000_0000 : 32'd0;
                end else begin
                    long_op = 1'b1;
                    case (op)
                        ALU_DIVU: r = a / b;
                        ALU_REMU: r = a % b;
                        ALU_DIV:  r = sa / sb;
                        default:  r = sa % sb;
                    endcase
                end
`else
                ok = 1'b0;
`endif
            end
            default:  ok = 1'b0;
        endcase
    endfunction

    // One clock of stimulus: drive at the falling edge, let the rising edge
    // act, then update the model.
    task automatic step(input logic rs, input logic v, input logic fl, input alu_opt_e op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic wr);
        logic        mready, acc, abort, ok, lo, pushed;
        logic [31:0] r;
        exp_t        e;
        @(negedge clk);
        mready = (cyc >= busy_until);
        if (!rs) begin
            chk("ready_o", {31'd0, bus.ready_o}, {31'd0, mready});
`ifdef MILANO_DIV_EN
            chk("busy_o", {31'd0, bus.busy_o}, {31'd0, !mready});
`else
            chk("busy_o", {31'd0, bus.busy_o}, 32'd0);
`endif
        end
        rst               = rs;
        bus.valid_i       = v;
        bus.flush_i       = fl;
        bus.alu_operate_i = op;
        bus.operand_a_i   = a;
        bus.operand_b_i   = b;
        bus.rd_addr_i     = rd;
        bus.rd_wr_en_i    = wr;
        acc   = !rs && v && !fl && mready;
        abort = (rs || fl) && !mready;
        ref_op(op, a, b, ok, r, lo);
        @(posedge clk);
        #1;
        if (abort) begin
            if (pend) void'(exp_q.pop_back());
            pend = 1'b0;
            busy_until = cyc;
        end
        if (rs) busy_until = cyc;
        if (acc) begin
            pushed = ok && wr && (rd != 5'd0);
            if (pushed) begin
                e.addr = rd;
                e.data = r;
                e.at   = cyc + (lo ? 32 : 0);
                exp_q.push_back(e);
            end
            pend = lo && pushed;
            if (lo) busy_until = cyc + 32;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    // Cycles during which the stage is busy: inputs toggle but must be ignored.
    task automatic junk(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b1, 1'b0, alu_opt_e'(4'($urandom_range(15))), $urandom, $urandom,
                 5'($urandom_range(31)), 1'b1);
    endtask

    // Observe outputs at the next falling edge without issuing anything.
    task automatic look();
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        look();
        chk("rst_we_o",    {31'd0, bus.we_o},   32'd0);
        chk("rst_waddr_o", {27'd0, bus.waddr_o}, 32'd0);
        chk("rst_wdata_o", bus.wdata_o,          32'd0);
        chk("rst_busy_o",  {31'd0, bus.busy_o}, 32'd0);
        chk("rst_ready_o", {31'd0, bus.ready_o}, 32'd1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy_o === 1'b1) busy_seen = 1'b1;
        if (bus.we_o === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL wb_unexpected: got we_o=1 addr %0d data %h at cycle %0d, required no writeback",
                         bus.waddr_o, bus.wdata_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.waddr_o === e.addr && bus.wdata_o === e.data && cyc == e.at)
                    n_pass++;
                else
                    $display("FAIL wb_result: got addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                             bus.waddr_o, bus.wdata_o, cyc, e.addr, e.data, e.at);
            end
        end
    end

    initial begin
        logic [31:0] a, b;
        alu_opt_e    op;
        int          sel;

        rst               = 1'b1;
        bus.valid_i       = 1'b0;
        bus.flush_i       = 1'b0;
        bus.alu_operate_i = ALU_ADD;
        bus.operand_a_i   = '0;
        bus.operand_b_i   = '0;
        bus.rd_addr_i     = '0;
        bus.rd_wr_en_i    = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
        chk_reset_outputs();

        // Overflowing add
        step(1'b0, 1'b1, 1'b0, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1);
        look();
        chk("add_ovf_wdata", bus.wdata_o, 32'h8000_0000);

        // Back-to-back SUB / SRA / SLTU
        step(1'b0, 1'b1, 1'b0, ALU_SUB,  32'd5,         32'd7, 5'd1, 1'b1);
        step(1'b0, 1'b1, 1'b0, ALU_SRA,  32'h8000_0000, 32'd4, 5'd2, 1'b1);
        step(1'b0, 1'b1, 1'b0, ALU_SLTU, 32'd1,         32'd2, 5'd3, 1'b1);
        look();
        chk("b2b_sltu_wdata", bus.wdata_o, 32'd1);

        // rd = 0: data updates, no strobe
        step(1'b0, 1'b1, 1'b0, ALU_ADD, 32'd40, 32'd2, 5'd0, 1'b1);
        look();
        chk("rd0_we_o",    {31'd0, bus.we_o}, 32'd0);
        chk("rd0_wdata_o", bus.wdata_o,        32'd42);

        // Unrecognised op: zero data, no strobe
        step(1'b0, 1'b1, 1'b0, alu_opt_e'(4'hF), 32'd5, 32'd6, 5'd3, 1'b1);
        look();
        chk("unk_we_o",    {31'd0, bus.we_o}, 32'd0);
        chk("unk_wdata_o", bus.wdata_o,        32'd0);

        // Flush together with valid in IDLE: nothing accepted
        step(1'b0, 1'b1, 1'b1, ALU_ADD, 32'd1, 32'd1, 5'd7, 1'b1);
        look();
        chk("flush_idle_we_o", {31'd0, bus.we_o}, 32'd0);

`ifdef MILANO_DIV_EN
        // Signed divide and remainder of -7 by 2
        step(1'b0, 1'b1, 1'b0, ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
        junk(32);
        look();
        chk("div_m7_2", bus.wdata_o, 32'hFFFF_FFFD);
        step(1'b0, 1'b1, 1'b0, ALU_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
        junk(32);
        look();
        chk("rem_m7_2", bus.wdata_o, 32'hFFFF_FFFF);

        // Special-case divides retire in one cycle
        step(1'b0, 1'b1, 1'b0, ALU_DIVU, 32'd9, 32'd0, 5'd8, 1'b1);
        look();
        chk("divu_by0",      bus.wdata_o,         32'hFFFF_FFFF);
        chk("divu_by0_busy", {31'd0, bus.busy_o}, 32'd0);
        step(1'b0, 1'b1, 1'b0, ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1);
        look();
        chk("div_ovf",      bus.wdata_o,         32'h8000_0000);
        chk("div_ovf_busy", {31'd0, bus.busy_o}, 32'd0);

        // Flush mid-divide
        step(1'b0, 1'b1, 1'b0, ALU_DIVU, 32'd100, 32'd3, 5'd6, 1'b1);
        junk(9);
        step(1'b0, 1'b0, 1'b1, ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
        look();
        chk("flush_div_ready", {31'd0, bus.ready_o}, 32'd1);
        idle(40);

        // Reset mid-divide, with valid and flush also high
        step(1'b0, 1'b1, 1'b0, ALU_DIVU, 32'd100, 32'd3, 5'd6, 1'b1);
        junk(9);
        step(1'b1, 1'b1, 1'b1, ALU_ADD, 32'd3, 32'd4, 5'd2, 1'b1);
        chk_reset_outputs();
        idle(40);
`else
        // Divides are inert without the divider
        step(1'b0, 1'b1, 1'b0, ALU_DIV, 32'd10, 32'd2, 5'd4, 1'b1);
        look();
        chk("nodiv_we_o",    {31'd0, bus.we_o},   32'd0);
        chk("nodiv_wdata_o", bus.wdata_o,          32'd0);
        chk("nodiv_busy_o",  {31'd0, bus.busy_o}, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            op  = alu_opt_e'(4'($urandom_range(15)));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(15));
            else if (sel == 3) a = 32'h8000_0000;
            step(1'b0, ($urandom_range(9) < 8), ($urandom_range(99) < 3), op, a, b,
                 5'($urandom_range(31)), 1'($urandom_range(1)));
        end

        // Drain outstanding results within a bounded number of cycles
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) idle(1);
        idle(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
`ifndef MILANO_DIV_EN
        chk("busy_never_seen", {31'd0, busy_seen}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
